uart_xcvr: RTL and testbench
============================

Name: uart_xcvr

Overview:
- Full-duplex 8-bit asynchronous serial transceiver (8N1, LSB first) with a runtime-programmable baud divider.
- Used on the board/bench side of the SoC serial link and inside the SoC for firmware upload and console.
- Byte-wide parallel interface: single-cycle TX strobe with a busy flag, single-cycle RX valid pulse.

Parameters:
- OVS, 16, oversample ticks per bit.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstb  input  1  asynchronous reset, active-high. Name kept per codebase; asserted = 1.
- baudrate_cfg  input  8  divider; one oversample tick every baudrate_cfg+1 clocks.
- rx  input  1  serial input, idle high, asynchronous to clk.
- tx  output  1  serial output, idle high.
- tx_valid  input  1  one-cycle strobe, load tx_data.
- tx_data  input  8  byte to send; sampled when tx_valid=1 and tx_busy=0.
- tx_busy  output  1  transmitter occupied.
- rx_valid  output  1  one-cycle pulse, rx_data holds a new byte.
- rx_data  output  8  last received byte; held until the next byte.

Behaviour:
- Reset values: tx=1, tx_busy=0, rx_valid=0, rx_data=0. Divider counter, both FSMs and the synchronizer (preset to 1) are cleared.
- Reset mid-frame: aborts both directions immediately; tx returns to 1 asynchronously.
- Tick generator: free-running counter 0..baudrate_cfg, one-cycle tick at wrap.
  - Shared by TX and RX.
  - baudrate_cfg=0 gives a tick every clock.
  - Bit time = OVS*(baudrate_cfg+1) clocks; cfg=6 gives 112 clocks.
  - A cfg change takes effect at the next counter wrap.
- TX accept:
  - tx_valid=1 with tx_busy=0 latches tx_data; tx_busy=1 from the next cycle.
  - tx_valid while busy is ignored, with no effect on the frame in flight.
- TX FSM: IDLE -> START (tx=0) -> DATA bits 0..7, LSB first -> STOP (tx=1) -> IDLE.
  - Each state lasts OVS ticks.
  - The start bit begins at the first tick after acceptance.
  - tx_busy deasserts in the cycle the stop bit's last tick completes.
  - A new tx_valid may be accepted that same cycle after busy drops, giving back-to-back frames.
- RX input: 2-flop synchronizer on rx; the FSM uses only the synchronized value.
- RX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: synchronized rx=0 enters START and resets the tick phase counter.
  - START: at tick OVS/2-1, if rx=1 the start is false and the FSM returns to IDLE; otherwise it enters DATA.
  - DATA: samples each bit at mid-bit (every OVS ticks) into a shift register, LSB first.
  - STOP: at mid stop bit:
    - rx=1: rx_data updated and rx_valid pulses for exactly one clock.
    - rx=0 (framing error): byte discarded, no pulse, FSM waits in STOP until rx=1, then IDLE.
- RX and TX are fully independent; simultaneous operation is required.
- Loopback (tx tied to rx) must work at any baudrate_cfg.

Optional Feature:
- UART_PARITY_EN defined:
  - Frame is 8E1; the even-parity bit follows bit 7 on TX.
  - RX checks parity. On mismatch, rx_valid is suppressed and rx_data is left unchanged.
- UART_PARITY_EN undefined: 8N1 exactly as above, with no parity logic.

Test Plan:
- Reset: rstb=1, then rstb=0 -> tx=1, tx_busy=0, rx_valid=0, rx_data=0.
- cfg=6, tx_valid pulse with tx_data=0xA5:
  - tx_busy=1 the next cycle.
  - tx low for 112 clocks, then bits 1,0,1,0,0,1,0,1 at 112 clocks each.
  - Stop high; busy drops 1120 clocks after start.
- Loopback, cfg=6, stream of 0x00, 0xFF, 0x55, 0x3C sent back-to-back by pulsing tx_valid whenever tx_busy=0 and the previous strobe is low:
  - Four rx_valid pulses in order.
  - rx_data matches each byte.
  - No gaps beyond one cycle between frames.
- tx_valid with tx_data=0x12 during busy -> ignored; the in-flight byte is unchanged on the line.
- RX glitch (rx low for 3 clocks, cfg=6) -> no rx_valid, FSM back in IDLE.
- Framing error (0x81 sent with the stop bit forced 0) -> no rx_valid. The next good byte 0x7E is received correctly.

Source files
------------

// File: rtl/uart_xcvr_if.sv
// Parallel-side and serial-line signals of the uart_xcvr transceiver.
interface uart_xcvr_if;
  logic [7:0] baudrate_cfg;
  logic       rx;
  logic       tx;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (
    output baudrate_cfg, rx, tx_valid, tx_data,
    input  tx, tx_busy, rx_valid, rx_data
  );

  modport slave (
    input  baudrate_cfg, rx, tx_valid, tx_data,
    output tx, tx_busy, rx_valid, rx_data
  );
endinterface

// File: rtl/uart_xcvr.sv
// Full-duplex 8N1 UART with programmable baud divider and OVS-times oversampling.
// Define UART_PARITY_EN for 8E1 frames (even parity after bit 7, checked on RX).
module uart_xcvr #(
  parameter int OVS = 16
) (
  input  logic        clk,
  input  logic        rstb,
  uart_xcvr_if.slave  bus
);

  localparam int PW = $clog2(OVS);
  localparam logic [PW-1:0] PH_ZERO = PW'(0);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [PW-1:0] PH_LAST = PW'(OVS - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(OVS / 2 - 1);

`ifdef UART_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  typedef enum logic [2:0] {
    TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PAR, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_FERR
  } rx_state_t;

  logic [7:0]    r_div_cnt;
  logic          w_tick;

  tx_state_t     r_tx_state;
  logic [PW-1:0] r_tx_ph;
  logic [2:0]    r_tx_bit;
  logic [2:0]    w_tx_bit_nxt;
  logic [7:0]    r_tx_data;
  logic          r_tx;
  logic          r_tx_busy;

  rx_state_t     r_rx_state;
  logic [PW-1:0] r_rx_ph;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_rx_meta;
  logic          r_rx_sync;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
`ifdef UART_PARITY_EN
  logic          r_rx_par_ok;
`endif

  // Compare with >= so a cfg lowered below the current count wraps at once.
  assign w_tick       = (r_div_cnt >= bus.baudrate_cfg);
  assign w_tx_bit_nxt = r_tx_bit + 3'd1;

  // Shared oversample tick divider.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_div_cnt <= 8'd0;
    end else if (w_tick) begin
      r_div_cnt <= 8'd0;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

  // Transmit FSM; TX_WAIT aligns the start bit to the next tick after accept.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_tx_state <= TX_IDLE;
      r_tx_ph    <= PH_ZERO;
      r_tx_bit   <= 3'd0;
      r_tx_data  <= 8'd0;
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (bus.tx_valid) begin
            r_tx_data  <= bus.tx_data;
            r_tx_busy  <= 1'b1;
            r_tx_state <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (w_tick) begin
            r_tx       <= 1'b0;
            r_tx_ph    <= PH_ZERO;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tick) begin
            if (r_tx_ph == PH_LAST) begin
              r_tx_ph    <= PH_ZERO;
              r_tx_bit   <= 3'd0;
              r_tx       <= r_tx_data[0];
              r_tx_state <= TX_DATA;
            end else begin
              r_tx_ph <= r_tx_ph + PH_ONE;
            end
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            if (r_tx_ph == PH_LAST) begin
              r_tx_ph <= PH_ZERO;
              if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                r_tx       <= even_parity(r_tx_data);
                r_tx_state <= TX_PAR;
`else
                r_tx       <= 1'b1;
                r_tx_state <= TX_STOP;
`endif
              end else begin
                r_tx_bit <= w_tx_bit_nxt;
                r_tx     <= r_tx_data[w_tx_bit_nxt];
              end
            end else begin
              r_tx_ph <= r_tx_ph + PH_ONE;
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PAR: begin
          if (w_tick) begin
            if (r_tx_ph == PH_LAST) begin
              r_tx_ph    <= PH_ZERO;
              r_tx       <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_ph <= r_tx_ph + PH_ONE;
            end
          end
        end
`endif
        TX_STOP: begin
          if (w_tick) begin
            if (r_tx_ph == PH_LAST) begin
              r_tx_ph    <= PH_ZERO;
              r_tx_busy  <= 1'b0;
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_ph <= r_tx_ph + PH_ONE;
            end
          end
        end
        default: begin
          r_tx       <= 1'b1;
          r_tx_busy  <= 1'b0;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous serial input, preset to idle.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receive FSM; START samples half a bit in so later samples land mid-bit.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_rx_state <= RX_IDLE;
      r_rx_ph    <= PH_ZERO;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par_ok <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_sync) begin
            r_rx_ph    <= PH_ZERO;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_rx_ph == PH_MID) begin
              r_rx_ph    <= PH_ZERO;
              r_rx_bit   <= 3'd0;
              r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
            end else begin
              r_rx_ph <= r_rx_ph + PH_ONE;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            if (r_rx_ph == PH_LAST) begin
              r_rx_ph    <= PH_ZERO;
              r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
              if (r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                r_rx_state <= RX_PAR;
`else
                r_rx_state <= RX_STOP;
`endif
              end else begin
                r_rx_bit <= r_rx_bit + 3'd1;
              end
            end else begin
              r_rx_ph <= r_rx_ph + PH_ONE;
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PAR: begin
          if (w_tick) begin
            if (r_rx_ph == PH_LAST) begin
              r_rx_ph     <= PH_ZERO;
              r_rx_par_ok <= (r_rx_sync == even_parity(r_rx_shift));
              r_rx_state  <= RX_STOP;
            end else begin
              r_rx_ph <= r_rx_ph + PH_ONE;
            end
          end
        end
`endif
        RX_STOP: begin
          if (w_tick) begin
            if (r_rx_ph == PH_LAST) begin
              r_rx_ph <= PH_ZERO;
              if (r_rx_sync) begin
`ifdef UART_PARITY_EN
                if (r_rx_par_ok) begin
                  r_rx_data  <= r_rx_shift;
                  r_rx_valid <= 1'b1;
                end
`else
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
`endif
                r_rx_state <= RX_IDLE;
              end else begin
                r_rx_state <= RX_FERR;
              end
            end else begin
              r_rx_ph <= r_rx_ph + PH_ONE;
            end
          end
        end
        RX_FERR: begin
          if (r_rx_sync) begin
            r_rx_state <= RX_IDLE;
          end
        end
        default: begin
          r_rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  assign bus.tx       = r_tx;
  assign bus.tx_busy  = r_tx_busy;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_data  = r_rx_data;

endmodule

// File: tb/tb_uart_xcvr.sv
// Self-checking bench for uart_xcvr: line timing, loopback scoreboard, RX error cases.
module tb_uart_xcvr;
  logic clk = 1'b0;
  logic rstb;
  logic loop_en;
  logic rx_drv;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_xcvr_if bus();

  uart_xcvr #(.OVS(16)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  assign bus.rx = loop_en ? bus.tx : rx_drv;

  always #5 clk = ~clk;

  // Collect every received byte for the scoreboard.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) got_q.push_back(bus.rx_data);
  end

  task automatic wait_tx_idle(input int limit);
    int n = 0;
    while (bus.tx_busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL tx_idle_timeout busy=%b expected 0", bus.tx_busy);
    end
  endtask

  task automatic pulse_tx(input logic [7:0] b);
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic bang_rx(input logic [7:0] b, input logic stop_bit, input int bclk);
    rx_drv = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (bclk) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx_drv = ^b;
    repeat (bclk) @(negedge clk);
`endif
    rx_drv = stop_bit;
    repeat (bclk) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    rstb = 1'b1;
    loop_en = 1'b0;
    rx_drv = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    bus.baudrate_cfg = 8'd6;
    repeat (3) @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b expected 1", bus.tx); end
    checks++;
    if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.tx_busy); end
    checks++;
    if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b expected 0", bus.rx_valid); end
    checks++;
    if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h expected 00", bus.rx_data); end
  endtask

  task automatic test_tx_frame();
    logic [7:0] b;
    logic line [0:10];
    int nb;
    int n;
    b = 8'hA5;
    line[0] = 1'b0;
    for (int i = 0; i < 8; i++) line[i+1] = b[i];
`ifdef UART_PARITY_EN
    line[9] = ^b;
    line[10] = 1'b1;
    nb = 11;
`else
    line[9] = 1'b1;
    line[10] = 1'b1;
    nb = 10;
`endif
    loop_en = 1'b0;
    bus.baudrate_cfg = 8'd6;
    @(negedge clk);
    pulse_tx(b);
    checks++;
    if (bus.tx_busy !== 1'b1) begin errors++; $display("FAIL tx_accept_busy got %b expected 1", bus.tx_busy); end
    n = 0;
    while (bus.tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (bus.tx !== 1'b0) begin errors++; $display("FAIL tx_start_timeout tx=%b expected 0", bus.tx); end
    repeat (111) @(negedge clk);
    checks++;
    if (bus.tx !== 1'b0) begin errors++; $display("FAIL tx_start_len got %b expected 0 at clock 111", bus.tx); end
    @(negedge clk);
    checks++;
    if (bus.tx !== line[1]) begin errors++; $display("FAIL tx_bit0_edge got %b expected %b", bus.tx, line[1]); end
    repeat (56) @(negedge clk);
    for (int k = 1; k < nb; k++) begin
      checks++;
      if (bus.tx !== line[k]) begin errors++; $display("FAIL tx_line_bit%0d got %b expected %b", k, bus.tx, line[k]); end
      if (k < nb - 1) repeat (112) @(negedge clk);
    end
    repeat (55) @(negedge clk);
    checks++;
    if (bus.tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_before_end got %b expected 1", bus.tx_busy); end
    @(negedge clk);
    checks++;
    if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL tx_busy_drop got %b expected 0", bus.tx_busy); end
  endtask

  task automatic test_busy_ignore();
    int n;
    loop_en = 1'b1;
    bus.baudrate_cfg = 8'd6;
    got_q.delete();
    exp_q.delete();
    @(negedge clk);
    exp_q.push_back(8'h3C);
    pulse_tx(8'h3C);
    repeat (300) @(negedge clk);
    pulse_tx(8'h12);
    wait_tx_idle(2000);
    n = 0;
    while (got_q.size() < 1 && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (got_q.size() < 1) begin
      errors++;
      $display("FAIL busy_ignore_rx_timeout got %0d bytes expected 1", got_q.size());
    end else begin
      logic [7:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL busy_ignore_byte got %h expected %h", g, e); end
    end
    repeat (1500) @(negedge clk);
    checks++;
    if (got_q.size() != 0 || bus.tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_extra got %0d extra bytes busy=%b expected 0 and 0", got_q.size(), bus.tx_busy);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] stream [0:3];
    logic [7:0] cfgs [0:2];
    int n;
    stream[0] = 8'h00; stream[1] = 8'hFF; stream[2] = 8'h55; stream[3] = 8'h3C;
    cfgs[0] = 8'd6; cfgs[1] = 8'd0; cfgs[2] = 8'd2;
    loop_en = 1'b1;
    got_q.delete();
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      bus.baudrate_cfg = cfgs[c];
      repeat (20) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        wait_tx_idle(2000);
        exp_q.push_back(stream[i]);
        pulse_tx(stream[i]);
        checks++;
        if (bus.tx_busy !== 1'b1) begin errors++; $display("FAIL loop_accept cfg=%0d idx=%0d busy=%b expected 1", cfgs[c], i, bus.tx_busy); end
      end
      n = 0;
      while (got_q.size() < 4 && n < 6000) begin @(negedge clk); n++; end
      checks++;
      if (got_q.size() != 4) begin errors++; $display("FAIL loop_count cfg=%0d got %0d expected 4", cfgs[c], got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        logic [7:0] g, e;
        g = got_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (g !== e) begin errors++; $display("FAIL loop_byte cfg=%0d got %h expected %h", cfgs[c], g, e); end
      end
      got_q.delete();
      exp_q.delete();
      wait_tx_idle(2000);
      repeat (40) @(negedge clk);
    end
  endtask

  task automatic test_glitch();
    int n;
    loop_en = 1'b0;
    rx_drv = 1'b1;
    bus.baudrate_cfg = 8'd6;
    got_q.delete();
    exp_q.delete();
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (400) @(negedge clk);
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL glitch_no_valid got %0d bytes expected 0", got_q.size()); end
    exp_q.push_back(8'hA5);
    bang_rx(8'hA5, 1'b1, 112);
    n = 0;
    while (got_q.size() < 1 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL glitch_next_count got %0d expected 1", got_q.size());
    end else begin
      logic [7:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL glitch_next_byte got %h expected %h", g, e); end
    end
  endtask

  task automatic test_framing();
    int n;
    loop_en = 1'b0;
    got_q.delete();
    exp_q.delete();
    repeat (50) @(negedge clk);
    bang_rx(8'h81, 1'b0, 112);
    repeat (300) @(negedge clk);
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL framing_no_valid got %0d bytes expected 0", got_q.size()); end
    exp_q.push_back(8'h7E);
    bang_rx(8'h7E, 1'b1, 112);
    n = 0;
    while (got_q.size() < 1 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL framing_next_count got %0d expected 1", got_q.size());
    end else begin
      logic [7:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL framing_next_byte got %h expected %h", g, e); end
    end
    checks++;
    if (bus.rx_data !== 8'h7E) begin errors++; $display("FAIL framing_rx_data_hold got %h expected 7e", bus.rx_data); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_busy_ignore();
    test_loopback();
    test_glitch();
    test_framing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
